data_mem_unit: RTL and testbench

- Data-memory stage directly downstream of the ALU in the non-pipelined MIPS datapath.
- Takes the ALU result as the byte address and performs loads and stores (byte, half, word) against an internal word-organised RAM.
- Access latency is configurable; completion is signalled with a busy/done handshake so the control FSM stalls until the result is ready.
- Load data goes to the writeback mux.

---
 rtl/data_mem_unit.sv | 142 ++++++++++++++
 tb/tb_data_mem_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// Data-memory stage behind the ALU: byte/half/word loads and stores against a
// word-organised RAM, with a configurable access latency and busy/done handshake.
module data_mem_unit #(
    parameter int DEPTH   = 256,
    parameter int AW      = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] read_data,
    output logic        mem_busy,
    output logic        mem_done,
    output logic        mem_err
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;

    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [1:0]    size_q;
    logic          sext_q;
    logic          write_q;

    logic [31:0]   mem [DEPTH];

    logic          req, misaligned, illegal, bad_req, commit;
    logic [AW-1:0] idx;
    logic          unused_addr;

    // Upper address bits are dropped so accesses wrap modulo DEPTH*4 bytes.
    assign unused_addr = ^addr[31:AW+2];
    assign idx         = addr_q[AW+1:2];

    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] sz,
                                                 input logic [1:0] a, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{a, 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   return sx ? {{24{b[7]}}, b} : {24'b0, b};
            2'b01:   return sx ? {{16{h[15]}}, h} : {16'b0, h};
            default: return word;
        endcase
    endfunction

    always_comb begin
        req        = mem_read | mem_write;
        illegal    = (size == 2'b11) || (mem_read && mem_write);
        misaligned = (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        bad_req    = illegal | misaligned;
        commit     = (state == ACCESS) && (cnt == '0);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = bad_req ? DONE : ACCESS;
            ACCESS:  if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_err   <= 1'b0;
            read_data <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req) begin
                        cnt     <= CW'(LATENCY - 1);
                        mem_err <= bad_req;
                    end
                end
                ACCESS: begin
                    if (cnt != '0)
                        cnt <= cnt - 1'b1;
                    else if (!write_q)
                        read_data <= load_extract(mem[idx], size_q, addr_q[1:0], sext_q);
                end
                DONE:    mem_err <= 1'b0;
                default: mem_err <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            addr_q  <= addr[AW+1:0];
            wdata_q <= write_data;
            size_q  <= size;
            sext_q  <= sign_ext;
            write_q <= mem_write;
        end
    end

    // Stores touch only the enabled byte lanes; the rest of the word is preserved.
    always_ff @(posedge clk) begin
        if (commit && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_mask(size_q, addr_q[1:0])[i])
                    mem[idx][8*i +: 8] <= lane_data(size_q, wdata_q)[8*i +: 8];
            end
        end
    end

    assign mem_busy = (state == ACCESS);
    assign mem_done = (state == DONE);

endmodule

// File: tb/tb_data_mem_unit.sv
module tb_data_mem_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write, sign_ext;
    logic [31:0] addr, write_data;
    logic [1:0]  size;
    logic [31:0] read_data;
    logic        mem_busy, mem_done, mem_err;

    logic        mem_read1, mem_write1, sign_ext1;
    logic [31:0] addr1, write_data1;
    logic [1:0]  size1;
    logic [31:0] read_data1;
    logic        mem_busy1, mem_done1, mem_err1;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    data_mem_unit #(.DEPTH(256), .AW(8), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .write_data(write_data), .size(size), .sign_ext(sign_ext),
        .read_data(read_data), .mem_busy(mem_busy), .mem_done(mem_done), .mem_err(mem_err)
    );

    data_mem_unit #(.DEPTH(256), .AW(8), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .mem_read(mem_read1), .mem_write(mem_write1),
        .addr(addr1), .write_data(write_data1), .size(size1), .sign_ext(sign_ext1),
        .read_data(read_data1), .mem_busy(mem_busy1), .mem_done(mem_done1), .mem_err(mem_err1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request on the LATENCY=2 unit, starting 1 time unit after a rising edge.
    // lat = cycle after the request edge in which mem_done is seen (0 if never seen).
    task automatic op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input logic sx,
                      output logic [31:0] rdata, output logic err, output int busy, output int lat);
        int n;
        mem_read = rd; mem_write = wr; addr = a; write_data = wd; size = sz; sign_ext = sx;
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        n = 1; busy = 0;
        while (!mem_done && n < 20) begin
            if (mem_busy) busy++;
            @(posedge clk); #1;
            n++;
        end
        lat   = mem_done ? n : 0;
        rdata = read_data;
        err   = mem_err;
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          busy, lat;
    logic [11:0] done_pat, busy_pat;
    int          consec;

    initial begin
        reset = 1'b1;
        mem_read = 0; mem_write = 0; addr = 0; write_data = 0; size = 2'b10; sign_ext = 0;
        mem_read1 = 0; mem_write1 = 0; addr1 = 0; write_data1 = 0; size1 = 2'b10; sign_ext1 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_read_data", read_data, 32'h0);
        check("reset_busy", {31'b0, mem_busy}, 32'h0);
        check("reset_done", {31'b0, mem_done}, 32'h0);
        check("reset_err", {31'b0, mem_err}, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a store must abort it.
        op(0, 1, 32'h10, 32'h11112222, 2'b10, 0, rd, er, busy, lat);
        op(1, 0, 32'h10, 32'h0, 2'b10, 0, rd, er, busy, lat);
        check("pre_reset_load", rd, 32'h11112222);
        mem_write = 1; addr = 32'h10; write_data = 32'hDEADBEEF; size = 2'b10;
        @(posedge clk); #1;
        mem_write = 0;
        check("midreset_in_access", {31'b0, mem_busy}, 32'h1);
        reset = 1'b1;
        #1;
        check("midreset_read_data", read_data, 32'h0);
        check("midreset_busy", {31'b0, mem_busy}, 32'h0);
        check("midreset_done", {31'b0, mem_done}, 32'h0);
        check("midreset_err", {31'b0, mem_err}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        op(1, 0, 32'h10, 32'h0, 2'b10, 0, rd, er, busy, lat);
        check("aborted_store_load", rd, 32'h11112222);

        // Word store then load.
        op(0, 1, 32'h40, 32'h12345678, 2'b10, 0, rd, er, busy, lat);
        check("st_word_busy", busy, 2);
        check("st_word_lat", lat, 3);
        check("st_word_err", {31'b0, er}, 32'h0);
        check("st_word_rd_unchanged", rd, 32'h11112222);
        check("done_single_pulse", {31'b0, mem_done}, 32'h0);
        op(1, 0, 32'h40, 32'h0, 2'b10, 0, rd, er, busy, lat);
        check("ld_word_data", rd, 32'h12345678);
        check("ld_word_busy", busy, 2);
        check("ld_word_lat", lat, 3);
        check("ld_word_err", {31'b0, er}, 32'h0);

        // Byte and half lanes.
        op(0, 1, 32'h41, 32'h000000AB, 2'b00, 0, rd, er, busy, lat);
        op(1, 0, 32'h41, 32'h0, 2'b00, 1, rd, er, busy, lat);
        check("ld_byte_sext", rd, 32'hFFFFFFAB);
        op(1, 0, 32'h41, 32'h0, 2'b00, 0, rd, er, busy, lat);
        check("ld_byte_zext", rd, 32'h000000AB);
        op(1, 0, 32'h42, 32'h0, 2'b01, 0, rd, er, busy, lat);
        check("ld_half_zext", rd, 32'h00001234);
        op(1, 0, 32'h40, 32'h0, 2'b10, 1, rd, er, busy, lat);
        check("ld_word_merged", rd, 32'h1234AB78);

        // Misaligned and illegal requests.
        op(1, 0, 32'h42, 32'h0, 2'b10, 0, rd, er, busy, lat);
        check("mis_word_err", {31'b0, er}, 32'h1);
        check("mis_word_lat", lat, 1);
        check("mis_word_busy", busy, 0);
        check("mis_word_rd", rd, 32'h1234AB78);
        check("err_cleared", {31'b0, mem_err}, 32'h0);
        op(0, 1, 32'h43, 32'h0000FFFF, 2'b01, 0, rd, er, busy, lat);
        check("mis_half_err", {31'b0, er}, 32'h1);
        check("mis_half_lat", lat, 1);
        check("mis_half_busy", busy, 0);
        op(1, 0, 32'h40, 32'h0, 2'b11, 0, rd, er, busy, lat);
        check("ill_size_err", {31'b0, er}, 32'h1);
        check("ill_size_lat", lat, 1);
        check("ill_size_rd", rd, 32'h1234AB78);
        op(1, 1, 32'h40, 32'h0, 2'b10, 0, rd, er, busy, lat);
        check("ill_both_err", {31'b0, er}, 32'h1);
        check("ill_both_lat", lat, 1);
        check("ill_both_busy", busy, 0);
        op(1, 0, 32'h40, 32'h0, 2'b10, 0, rd, er, busy, lat);
        check("ram_after_errors", rd, 32'h1234AB78);
        check("ram_after_errors_err", {31'b0, er}, 32'h0);

        // Wrap-around of the address space.
        op(0, 1, 32'h400, 32'hCAFEF00D, 2'b10, 0, rd, er, busy, lat);
        op(1, 0, 32'h0, 32'h0, 2'b10, 0, rd, er, busy, lat);
        check("wrap_load", rd, 32'hCAFEF00D);

        // LATENCY=1 unit with mem_read held high.
        mem_read1 = 1'b1;
        done_pat = '0; busy_pat = '0; consec = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            done_pat[i] = mem_done1;
            busy_pat[i] = mem_busy1;
            if (i > 0 && done_pat[i] && done_pat[i-1]) consec++;
        end
        mem_read1 = 1'b0;
        check("lat1_done_pattern", {20'b0, done_pat}, 32'h492);
        check("lat1_busy_pattern", {20'b0, busy_pat}, 32'h249);
        check("lat1_no_consec_done", consec, 0);
        check("lat1_err", {31'b0, mem_err1}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
